// File: rtl/game_spawner_if.sv
// Spawn offer channel between the spawner and the object/sprite logic.
interface game_spawner_if;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [9:0] spawn_x;
  logic       spawn_dir;

  modport master (output spawn_valid, output spawn_x, output spawn_dir, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_x, input spawn_dir, output spawn_ready);
endinterface

// File: rtl/game_spawner.sv
// Waits a pseudo-random delay, then offers a new object (column, direction)
// over a valid/ready channel and holds off until the object is reported done.
module game_spawner #(
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned DELAY_MIN = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [15:0]           random,
  game_spawner_if.master        spawn,
  input  logic                  object_done,
  output logic                  busy,
  output logic [7:0]            spawn_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OFFER, S_ACTIVE} state_t;

  localparam logic [9:0] X_LIM    = 10'(X_MAX);
  localparam logic [9:0] X_SPAN   = 10'(X_MAX + 1);
  localparam logic [8:0] DELAY_LD = 9'(DELAY_MIN);

  state_t     state;
  logic [8:0] delay;
  logic [9:0] x_q;
  logic       dir_q;
  logic [9:0] raw;

  assign raw = random[15:6];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      delay       <= '0;
      x_q         <= '0;
      dir_q       <= 1'b0;
      spawn_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            delay <= DELAY_LD + {1'b0, random[7:0]};
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (delay != '0) begin
            delay <= delay - 9'd1;
          end else begin
            // Fold out-of-range columns back onto the screen.
            x_q   <= (raw > X_LIM) ? raw - X_SPAN : raw;
            dir_q <= random[0];
            state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (spawn.spawn_ready) begin
            state <= S_ACTIVE;
            if (spawn_count != 8'hFF) spawn_count <= spawn_count + 8'd1;
          end
        end
        S_ACTIVE: begin
          if (object_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign spawn.spawn_valid = (state == S_OFFER);
  assign spawn.spawn_x     = x_q;
  assign spawn.spawn_dir   = dir_q;
  assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_game_spawner.sv
// Directed bench for game_spawner: table of spawn vectors plus corner sequences.
module tb_game_spawner;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        object_done = 1'b0;
  logic [15:0] random = '0;
  logic        busy;
  logic [7:0]  spawn_count;

  game_spawner_if sif ();

  game_spawner #(.X_MAX(639), .DELAY_MIN(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .random      (random),
    .spawn       (sif),
    .object_done (object_done),
    .busy        (busy),
    .spawn_count (spawn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rnd;
    int          lat;
    int          x;
    logic        dir;
  } vec_t;

  vec_t vecs [7];
  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at the negedge right after WAIT entry; lat = edges until valid seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (sif.spawn_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sif.spawn_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_valid timeout actual=0 required=1");
    end
  endtask

  task automatic start_spawn(input logic [15:0] r);
    random = r;
    enable = 1'b1;
    @(negedge clk);
    check("enter_wait_busy", busy, 1);
    check("enter_wait_valid", sif.spawn_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0005,  22,   0, 1'b1};
    vecs[1] = '{16'hFFC0, 209, 383, 1'b0};
    vecs[2] = '{16'h9FC0, 209, 639, 1'b0};
    vecs[3] = '{16'h0000,  17,   0, 1'b0};
    vecs[4] = '{16'hA001,  18,   0, 1'b1};
    vecs[5] = '{16'h1234,  69,  72, 1'b0};
    vecs[6] = '{16'hFFFF, 272, 383, 1'b1};

    sif.spawn_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", sif.spawn_valid, 0);
    check("rst_x", sif.spawn_x, 0);
    check("rst_dir", sif.spawn_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_count", spawn_count, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    foreach (vecs[i]) begin
      start_spawn(vecs[i].rnd);
      wait_valid(lat);
      check("vec_latency", lat, vecs[i].lat);
      check("vec_x", sif.spawn_x, vecs[i].x);
      check("vec_dir", sif.spawn_dir, vecs[i].dir);
      check("vec_count_pre", spawn_count, exp_count);
      sif.spawn_ready = 1'b1;
      @(negedge clk);
      sif.spawn_ready = 1'b0;
      exp_count++;
      check("vec_valid_drop", sif.spawn_valid, 0);
      check("vec_active_busy", busy, 1);
      check("vec_count", spawn_count, exp_count);
      enable = 1'b0;
      object_done = 1'b1;
      @(negedge clk);
      object_done = 1'b0;
      check("vec_idle_busy", busy, 0);
      check("vec_x_held", sif.spawn_x, vecs[i].x);
    end

    // Backpressure: offer held stable while ready is low.
    start_spawn(16'h1234);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", sif.spawn_valid, 1);
      check("bp_x", sif.spawn_x, 72);
      check("bp_dir", sif.spawn_dir, 0);
      check("bp_count", spawn_count, exp_count);
    end
    sif.spawn_ready = 1'b1;
    @(negedge clk);
    sif.spawn_ready = 1'b0;
    exp_count++;
    check("bp_xfer_valid", sif.spawn_valid, 0);
    check("bp_xfer_count", spawn_count, exp_count);

    // enable low in ACTIVE is ignored.
    enable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("active_hold_busy", busy, 1);
    end
    object_done = 1'b1;
    @(negedge clk);
    object_done = 1'b0;
    check("active_done_busy", busy, 0);

    // object_done and spawn_ready in IDLE do nothing.
    object_done = 1'b1;
    sif.spawn_ready = 1'b1;
    @(negedge clk);
    object_done = 1'b0;
    sif.spawn_ready = 1'b0;
    @(negedge clk);
    check("idle_ign_busy", busy, 0);
    check("idle_ign_valid", sif.spawn_valid, 0);
    check("idle_ign_count", spawn_count, exp_count);

    // Asynchronous reset mid-WAIT.
    start_spawn(16'hFFFF);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wait_busy", busy, 0);
    check("rst_wait_count", spawn_count, 0);
    check("rst_wait_x", sif.spawn_x, 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
    @(negedge clk);
    check("rst_wait_idle", busy, 0);

    // Abort in WAIT.
    start_spawn(16'h0000);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_wait_busy", busy, 0);
    check("abort_wait_count", spawn_count, exp_count);

    // Abort in OFFER together with ready: abort wins.
    start_spawn(16'h0000);
    wait_valid(lat);
    enable = 1'b0;
    sif.spawn_ready = 1'b1;
    @(negedge clk);
    sif.spawn_ready = 1'b0;
    check("abort_offer_valid", sif.spawn_valid, 0);
    check("abort_offer_busy", busy, 0);
    check("abort_offer_count", spawn_count, exp_count);

    // Zero-wait transfer with ready already high.
    sif.spawn_ready = 1'b1;
    start_spawn(16'h0005);
    wait_valid(lat);
    check("zw_latency", lat, 22);
    @(negedge clk);
    exp_count++;
    check("zw_valid_drop", sif.spawn_valid, 0);
    check("zw_busy", busy, 1);
    check("zw_count", spawn_count, exp_count);
    sif.spawn_ready = 1'b0;
    enable = 1'b0;
    object_done = 1'b1;
    @(negedge clk);
    object_done = 1'b0;

    // Asynchronous reset mid-OFFER: offer lost and not counted.
    start_spawn(16'hFFC0);
    wait_valid(lat);
    check("pre_rst_offer_x", sif.spawn_x, 383);
    reset = 1'b0;
    #1;
    check("rst_offer_valid", sif.spawn_valid, 0);
    check("rst_offer_x", sif.spawn_x, 0);
    check("rst_offer_busy", busy, 0);
    check("rst_offer_count", spawn_count, 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
    @(negedge clk);

    // Saturation over 260 back-to-back spawns.
    sif.spawn_ready = 1'b1;
    random = 16'h0000;
    enable = 1'b1;
    for (int n = 0; n < 260; n++) begin
      @(negedge clk);
      wait_valid(lat);
      @(negedge clk);
      if (exp_count < 255) exp_count++;
      check("sat_count", spawn_count, exp_count);
      object_done = 1'b1;
      @(negedge clk);
      object_done = 1'b0;
    end
    check("sat_final", spawn_count, 255);
    @(negedge clk);
    wait_valid(lat);
    check("sat_still_spawns", sif.spawn_valid, 1);
    @(negedge clk);
    check("sat_hold", spawn_count, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
